wdata_fifo_v2: RTL and testbench

WDATA_FIFO_V2 -- requirements
Module: wdata_fifo_v2

---
 rtl/wdata_fifo_pkg.sv | 26 ++
 rtl/wdata_fifo_ram.sv | 27 ++
 rtl/wdata_fifo_v2.sv | 129 ++++++++++++
 tb/tb_wdata_fifo_v2.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/wdata_fifo_pkg.sv
// Shared defaults, error-flag record and a clog2 helper for the write-data FIFO.
package wdata_fifo_pkg;

    localparam int DEFAULT_DW       = 32;
    localparam int DEFAULT_DEPTH    = 32;
    localparam int DEFAULT_AF_SPACE = 2;

    // Sticky error flags kept together so they share one register.
    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    // Ceiling log2, usable in parameter/localparam expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/wdata_fifo_ram.sv
// Storage array for wdata_fifo_v2: one synchronous write port, one
// asynchronous read port. Contents are deliberately not reset.
module wdata_fifo_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port: store one entry per accepted write.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wdata_fifo_v2.sv
// Single-clock first-word-fall-through write-data FIFO with sticky
// overflow/underflow flags. Define WDATA_FIFO_PARITY_EN to store an even
// parity bit per entry and expose a sticky parity_err output.
module wdata_fifo_v2
    import wdata_fifo_pkg::*;
#(
    parameter int DW       = DEFAULT_DW,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AF_SPACE = DEFAULT_AF_SPACE,
    localparam int AW      = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wen,
    input  logic [DW-1:0] data_in,
    input  logic          ren,
    output logic [DW-1:0] data_out,
    output logic          full,
    output logic          virtual_full,
    output logic          empty,
    output logic [AW:0]   count,
    input  logic          clr_err,
    output logic          overflow,
    output logic          underflow
`ifdef WDATA_FIFO_PARITY_EN
   ,output logic          parity_err
`endif
);

`ifdef WDATA_FIFO_PARITY_EN
    localparam int RW = DW + 1;
`else
    localparam int RW = DW;
`endif

    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    fifo_err_t     err_q, err_d;
    logic [AW:0]   count_w;
    logic [31:0]   free_space;
    logic          full_w, empty_w;
    logic          wr_accept, rd_accept;
    logic [RW-1:0] ram_wdata, ram_rdata;

    // Occupancy from wrap-bit pointers; the subtraction is modulo 2*DEPTH.
    assign count_w      = wr_ptr_q - rd_ptr_q;
    assign full_w       = (count_w == DEPTH_CNT);
    assign empty_w      = (wr_ptr_q == rd_ptr_q);
    assign free_space   = 32'(DEPTH) - 32'(count_w);

    assign count        = count_w;
    assign full         = full_w;
    assign empty        = empty_w;
    assign virtual_full = (free_space < 32'(AF_SPACE));
    assign overflow     = err_q.overflow;
    assign underflow    = err_q.underflow;

    // Simultaneous wen/ren at full drops the write, at empty ignores the read.
    assign wr_accept = wen & ~full_w;
    assign rd_accept = ren & ~empty_w;

    // Next pointers and sticky flags; a new error beats a same-cycle clear.
    always_comb begin
        wr_ptr_d          = wr_ptr_q;
        rd_ptr_d          = rd_ptr_q;
        err_d             = err_q;
        if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
        if (clr_err)   err_d = '0;
        if (wen && full_w)  err_d.overflow  = 1'b1;
        if (ren && empty_w) err_d.underflow = 1'b1;
    end

    // Pointer and error-flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
        end
    end

`ifdef WDATA_FIFO_PARITY_EN
    logic parity_err_q, parity_err_d;

    assign ram_wdata = {^data_in, data_in};
    assign data_out  = ram_rdata[DW-1:0];
    assign parity_err = parity_err_q;

    // Sticky parity error on any accepted read whose stored parity mismatches.
    always_comb begin
        parity_err_d = parity_err_q;
        if (clr_err) parity_err_d = 1'b0;
        if (rd_accept && ((^ram_rdata[DW-1:0]) != ram_rdata[DW])) parity_err_d = 1'b1;
    end

    // Parity error register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end
`else
    assign ram_wdata = data_in;
    assign data_out  = ram_rdata;
`endif

    wdata_fifo_ram #(
        .WIDTH (RW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_accept),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (ram_wdata),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_wdata_fifo_v2.sv
// Directed scoreboard bench for wdata_fifo_v2 (DW=32, DEPTH=32, AF_SPACE=2).
module tb_wdata_fifo_v2;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wen, ren, clr_err;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          full, virtual_full, empty, overflow, underflow;
    logic [AW:0]   count;
`ifdef WDATA_FIFO_PARITY_EN
    logic          parity_err;
`endif

    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;

    logic [DW-1:0] sb[$];
    int            mcount = 0;
    logic          movf = 1'b0;
    logic          mudf = 1'b0;

    always #5 clk = ~clk;

    wdata_fifo_v2 #(
        .DW       (32),
        .DEPTH    (32),
        .AF_SPACE (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wen          (wen),
        .data_in      (data_in),
        .ren          (ren),
        .data_out     (data_out),
        .full         (full),
        .virtual_full (virtual_full),
        .empty        (empty),
        .count        (count),
        .clr_err      (clr_err),
        .overflow     (overflow),
        .underflow    (underflow)
`ifdef WDATA_FIFO_PARITY_EN
       ,.parity_err   (parity_err)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status();
        chk("count",        64'(count),        64'(mcount));
        chk("empty",        64'(empty),        64'(mcount == 0));
        chk("full",         64'(full),         64'(mcount == DEPTH));
        chk("virtual_full", 64'(virtual_full), 64'((DEPTH - mcount) < 2));
        chk("overflow",     64'(overflow),     64'(movf));
        chk("underflow",    64'(underflow),    64'(mudf));
    endtask

    // One clock: drive inputs, check head data for an accepted read, update model.
    task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d, input logic c);
        logic [DW-1:0] exp;
        wen = w; ren = r; data_in = d; clr_err = c;
        if (r && mcount > 0) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 64'd1, 64'd0);
            end else begin
                exp = sb.pop_front();
                chk("data_out", 64'(data_out), 64'(exp));
            end
        end
        movf = (movf && !c) || (w && mcount == DEPTH);
        mudf = (mudf && !c) || (r && mcount == 0);
        if (w && mcount < DEPTH) sb.push_back(d);
        mcount = mcount + ((w && mcount < DEPTH) ? 1 : 0) - ((r && mcount > 0) ? 1 : 0);
        @(posedge clk);
        #1;
        wen = 1'b0; ren = 1'b0; clr_err = 1'b0;
        chk_status();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; wen = 1'b0; ren = 1'b0; clr_err = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_status();

        // Fill with 0x00..0x1F.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'(i), 1'b0);

        // Write-only while full: dropped, overflow set; then clear.
        cycle(1'b1, 1'b0, 32'hDEAD, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1);
        // wen+ren while full: read happens, write dropped.
        cycle(1'b1, 1'b1, 32'hDEAD, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1);

        // Drain the remaining 31 entries.
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 1'b1, '0, 1'b0);

        // Read at empty coincident with clear: new error wins; then clear.
        cycle(1'b0, 1'b1, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1);

        // wen+ren while empty: write taken, read ignored, underflow set.
        cycle(1'b1, 1'b1, 32'hA5, 1'b0);
        chk("udf_head", 64'(data_out), 64'h00A5);

        // Bring count to 5 and stream 100 concurrent write/read cycles.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h100 + DW'(i), 1'b0);
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1, $urandom, 1'b0);

        // Reach 17 entries and reset mid-operation.
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, $urandom, 1'b0);
        chk("pre_rst_count", 64'(count), 64'd17);
        rst_n = 1'b0; wen = 1'b1; data_in = 32'hBAD0;
        @(posedge clk);
        #1;
        rst_n = 1'b1; wen = 1'b0;
        sb.delete(); mcount = 0; movf = 1'b0; mudf = 1'b0;
        chk_status();

        // Normal operation after reset.
        cycle(1'b1, 1'b0, 32'h1234_5678, 1'b0);
        cycle(1'b1, 1'b1, 32'h8765_4321, 1'b0);
        cycle(1'b0, 1'b1, '0, 1'b0);

`ifdef WDATA_FIFO_PARITY_EN
        begin
            logic [DW:0] ent;
            chk("parity_clean", 64'(parity_err), 64'd0);
            cycle(1'b1, 1'b0, 32'h0000_1234, 1'b0);
            ent = dut.u_ram.mem_q[2];
            ent[0] = ~ent[0];
            dut.u_ram.mem_q[2] = ent;
            sb[0] = 32'h0000_1235;
            cycle(1'b0, 1'b1, '0, 1'b0);
            chk("parity_err", 64'(parity_err), 64'd1);
            cycle(1'b0, 1'b0, '0, 1'b1);
            chk("parity_clr", 64'(parity_err), 64'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
